lud_nxn_seq: RTL and testbench
==============================

Name: lud_nxn_seq

Overview:
- Sequential, parametrised LU decomposition engine (Doolittle, no pivoting) for an N x N signed fixed-point matrix. Successor to the fixed 2x2 decomposer.
- Takes a packed matrix A on a start pulse and runs in-place Gaussian elimination with one shared divider and one shared multiplier.
- Presents a unit-lower L and an upper U, each packed, with a done pulse and a singular-pivot error.
- Sits between the matrix loader and the downstream solver in the LUD datapath.

Parameters:
N, 2, matrix dimension (2..4)
W, 16, element width, two's complement
FRAC, 8, fractional bits of the Q(W-FRAC).FRAC format (FRAC < W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle request; sampled only in IDLE
A  in  N*N*W  input matrix, row-major; element (i,j) at bits [(i*N+j)*W +: W]
busy  out  1  high from the cycle after start is accepted until done
done  out  1  1-cycle pulse when L/U are valid or on error
err  out  1  zero pivot detected; valid with done, held until next start
ovf  out  1  sticky arithmetic saturation flag (see Optional Feature)
L  out  N*N*W  unit lower matrix, same packing; diagonal = 1.0 (1<<FRAC), upper = 0
U  out  N*N*W  upper matrix, same packing; strictly lower = 0

Behaviour:
- Reset is asynchronous, active-low, and takes effect mid-operation. It forces the FSM to IDLE and sets busy=0, done=0, err=0, ovf=0. L is forced to the identity (diagonal 1<<FRAC, all other elements 0) and U to all-zero.
- FSM states:
  - IDLE: on start=1, capture A into the working array a[][], clear err/ovf, set k=0, i=1, go to DIV.
  - DIV:
    - If a[k][k]==0: err=1, go to FIN.
    - Otherwise run a restoring divider, l = (a[i][k] << FRAC) / a[k][k], signed, truncated toward zero, then saturated to W bits.
    - Takes exactly W+FRAC+1 cycles. Store l in L(i,k), then go to UPD with j=k.
  - UPD: one column per cycle for j=k..N-1: a[i][j] = a[i][j] - ((l * a[k][j]) >>> FRAC), arithmetic shift. Uses N-k cycles, then goes to NXT.
  - NXT: one cycle.
    - i<N-1: i++, go to DIV.
    - Else if k<N-2: k++, i=k+1, go to DIV.
    - Else go to FIN.
  - FIN: one cycle. Copy the upper triangle of a[][] into U and assert done. If err, leave L and U at their prior values. Return to IDLE.
- Latency: start sampled at edge t0 -> done high after edge t0+T. T = 1 + sum over k=0..N-2, i=k+1..N-1 of (W+FRAC+1 + (N-k) + 1).
  - N=2, W=16, FRAC=8: T = 1 + (25+2+1) = 29.
- busy is high for cycles t0+1 .. t0+T-1 and drops in the same cycle done is high.
- start while busy is ignored; A is not re-sampled.
- done and start in the same cycle: start is accepted on the following IDLE cycle only. done never coincides with IDLE.
- L and U change only in FIN (or on reset) and hold between runs.
- Zero pivot encountered at any k aborts the run immediately: done=1, err=1 at the FIN cycle, regardless of remaining iterations.

Optional Feature:
Macro LUD_SAT_EN.
- Defined:
  - Every subtract in UPD and the divider result saturate to [-2^(W-1), 2^(W-1)-1].
  - Any saturation event sets ovf, which stays sticky until the next accepted start or reset.
- Undefined:
  - Arithmetic wraps modulo 2^W and the divider result is truncated to W bits.
  - ovf is tied 0; the port remains present.

Test Plan:
1. Reset mid-run: assert rst_n=0 during DIV of a 3x3 run -> busy=0, done=0, L=identity, U=0 immediately (asynchronous). The next start completes normally.
2. N=2, A=[[1,2],[5,4]] in Q8.8 (0x0100,0x0200,0x0500,0x0400), start -> done exactly 29 cycles later. Required values: L(1,0)=0x0500, L diag=0x0100, U=[[0x0100,0x0200],[0,0xFA00]], err=0.
3. N=2, A=[[4,3],[6,3]] Q8.8 -> L(1,0)=0x0180, U(1,1)=0xFE80 (-1.5), U(0,*)=0x0400,0x0300.
4. N=3, A=[[2,1,1],[4,3,3],[8,7,9]] -> L=[[1,0,0],[2,1,0],[4,3,1]], U=[[2,1,1],[0,1,1],[0,0,2]] (all in Q8.8). T=1+(25+3+1)*2+(25+2+1)=87.
5. Zero pivot: A=[[0,1],[1,0]] -> done after 2 cycles with err=1; L and U unchanged from the previous run. Also apply a second start pulse while busy -> ignored.
6. LUD_SAT_EN: A=[[1/256 (0x0001), 1],[127,0]] -> divider saturates L(1,0)=0x7FFF and ovf=1. Without the macro, ovf=0 and L(1,0) wraps.

Source files
------------

// File: rtl/lud_nxn_seq.sv
// lud_nxn_seq: in-place Doolittle LU (no pivoting) of an NxN Q(W-FRAC).FRAC matrix, one divider, one multiplier.
// Latency: 1 + sum over k, i>k of (W+FRAC+1 + N-k + 1) cycles start->done; zero pivot aborts early.
// Backpressure: none; start ignored unless idle. LUD_SAT_EN enables saturation and the sticky ovf flag.

module lud_nxn_seq #(
   parameter int N    = 2,
   parameter int W    = 16,
   parameter int FRAC = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [N*N*W-1:0] A,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             ovf,
   output logic [N*N*W-1:0] L,
   output logic [N*N*W-1:0] U
);

   localparam int DW = W + FRAC;
   localparam int XW = 2*W + FRAC + 2;
   localparam int CW = $clog2(DW + 1);
   localparam int AW = $clog2(N);
   localparam logic [AW-1:0] NM1 = AW'(N - 1);
   localparam logic [AW-1:0] NM2 = AW'(N - 2);
   localparam logic [W-1:0]  ONE = W'(1 << FRAC);
`ifdef LUD_SAT_EN
   localparam logic signed [XW-1:0] SMAX = {{(XW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [XW-1:0] SMIN = {{(XW-W+1){1'b1}}, {(W-1){1'b0}}};
`endif

   typedef enum logic [2:0] {IDLE, DIV, UPD, NXT, FIN} state_t;

   state_t              st;
   logic signed [W-1:0] a    [N][N];
   logic signed [W-1:0] lw   [N][N];
   logic        [W-1:0] lmat [N][N];
   logic        [W-1:0] umat [N][N];
   logic [AW-1:0]       k, i, j;
   logic [CW-1:0]       cnt;
   logic [W-1:0]        rem;
   logic [DW-1:0]       quo;
   logic                ovf_r;

   logic signed [W-1:0]    piv, num;
   logic [W-1:0]           piv_mag, num_mag, r_in, rem_nx;
   logic [W:0]             shf;
   logic                   ge;
   logic [DW-1:0]          q_in, quo_nx;
   logic signed [2*W-1:0]  prod, sh;
   logic signed [XW-1:0]   qx, ax, sx, dx;
   logic [W:0]             qsat, dsat;

   // {saturation hit, W-bit result}; plain two's complement wrap when saturation is off
   function automatic logic [W:0] sat(input logic signed [XW-1:0] v);
`ifdef LUD_SAT_EN
      if (v > SMAX) return {1'b1, SMAX[W-1:0]};
      if (v < SMIN) return {1'b1, SMIN[W-1:0]};
`endif
      return {1'b0, v[W-1:0]};
   endfunction

   always_comb begin
      piv     = a[k][k];
      num     = a[i][k];
      piv_mag = piv[W-1] ? -piv : piv;
      num_mag = num[W-1] ? -num : num;
      // first divider step pulls the operands straight from the working array
      q_in    = (cnt == '0) ? {num_mag, {FRAC{1'b0}}} : quo;
      r_in    = (cnt == '0) ? '0 : rem;
      shf     = {r_in, q_in[DW-1]};
      ge      = shf >= {1'b0, piv_mag};
      rem_nx  = ge ? shf[W-1:0] - piv_mag : shf[W-1:0];
      quo_nx  = {q_in[DW-2:0], ge};
      qx      = $signed({{(XW-DW){1'b0}}, quo});
      if (num[W-1] ^ piv[W-1]) qx = -qx;
      prod    = lw[i][k] * a[k][j];
      sh      = prod >>> FRAC;
      ax      = a[i][j];
      sx      = sh;
      dx      = ax - sx;
      qsat    = sat(qx);
      dsat    = sat(dx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st    <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         ovf_r <= 1'b0;
         k     <= '0;
         i     <= '0;
         j     <= '0;
         cnt   <= '0;
         rem   <= '0;
         quo   <= '0;
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               a[r][c]    <= '0;
               lw[r][c]   <= '0;
               lmat[r][c] <= (r == c) ? ONE : '0;
               umat[r][c] <= '0;
            end
         end
      end else begin
         done <= 1'b0;
         case (st)
            IDLE: if (start) begin
               for (int r = 0; r < N; r++)
                  for (int c = 0; c < N; c++)
                     a[r][c] <= A[(r*N+c)*W +: W];
               err   <= 1'b0;
               ovf_r <= 1'b0;
               k     <= '0;
               i     <= AW'(1);
               cnt   <= '0;
               busy  <= 1'b1;
               st    <= DIV;
            end
            DIV: begin
               if (cnt == '0 && piv == '0) begin
                  err  <= 1'b1;
                  busy <= 1'b0;
                  done <= 1'b1;
                  st   <= FIN;
               end else if (cnt == CW'(DW)) begin
                  lw[i][k] <= qsat[W-1:0];
                  ovf_r    <= ovf_r | qsat[W];
                  j        <= k;
                  cnt      <= '0;
                  st       <= UPD;
               end else begin
                  rem <= rem_nx;
                  quo <= quo_nx;
                  cnt <= cnt + CW'(1);
               end
            end
            UPD: begin
               a[i][j] <= dsat[W-1:0];
               ovf_r   <= ovf_r | dsat[W];
               if (j == NM1) st <= NXT;
               else          j  <= j + AW'(1);
            end
            NXT: begin
               if (i < NM1) begin
                  i  <= i + AW'(1);
                  st <= DIV;
               end else if (k < NM2) begin
                  k  <= k + AW'(1);
                  i  <= k + AW'(2);
                  st <= DIV;
               end else begin
                  // publish on entry to FIN so L/U are already valid while done is high
                  for (int r = 0; r < N; r++) begin
                     for (int c = 0; c < N; c++) begin
                        lmat[r][c] <= (r == c) ? ONE : (r > c) ? lw[r][c] : '0;
                        umat[r][c] <= (c >= r) ? a[r][c] : '0;
                     end
                  end
                  busy <= 1'b0;
                  done <= 1'b1;
                  st   <= FIN;
               end
            end
            FIN:     st <= IDLE;
            default: st <= IDLE;
         endcase
      end
   end

   assign ovf = ovf_r;

   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         assign L[(r*N+c)*W +: W] = lmat[r][c];
         assign U[(r*N+c)*W +: W] = umat[r][c];
      end
   end

endmodule

// File: tb/tb_lud_nxn_seq.sv
// Self-checking bench for lud_nxn_seq: N=2 and N=3 instances against an arithmetic LU reference model.
module tb_lud_nxn_seq;
   localparam int W = 16;
   localparam int FRAC = 8;
   localparam longint M = (64'sd1 <<< W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic           start2, busy2, done2, err2, ovf2;
   logic [4*W-1:0] A2, L2, U2;
   logic           start3, busy3, done3, err3, ovf3;
   logic [9*W-1:0] A3, L3, U3;

   lud_nxn_seq #(.N(2), .W(W), .FRAC(FRAC)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .A(A2), .busy(busy2),
      .done(done2), .err(err2), .ovf(ovf2), .L(L2), .U(U2));
   lud_nxn_seq #(.N(3), .W(W), .FRAC(FRAC)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .A(A3), .busy(busy3),
      .done(done3), .err(err3), .ovf(ovf3), .L(L3), .U(U3));

   int     checks = 0;
   int     errors = 0;
   longint ma [4][4];
   longint eL [2][4][4];
   longint eU [2][4][4];
   bit     eErr [2];
   bit     eOvf [2];
   int     eT;
   bit     mo;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // bring an exact result back into W bits: clamp with saturation, wrap without
   function automatic longint fitw(input longint v);
      longint t;
`ifdef LUD_SAT_EN
      if (v > (M >> 1)) begin mo = 1'b1; return M >> 1; end
      if (v < -((M >> 1) + 1)) begin mo = 1'b1; return -((M >> 1) + 1); end
      return v;
`else
      t = v & M;
      if (t > (M >> 1)) t -= (M + 1);
      return t;
`endif
   endfunction

   task automatic model(input int d, input int n);
      longint a [4][4];
      longint lw [4][4];
      longint l;
      bit bad;
      a = ma;
      lw = '{default: 0};
      mo = 1'b0;
      bad = 1'b0;
      eT = 1;
      for (int k = 0; k < n - 1 && !bad; k++) begin
         for (int i = k + 1; i < n && !bad; i++) begin
            if (a[k][k] == 0) begin
               bad = 1'b1;
               eT += 1;
            end else begin
               l = fitw((a[i][k] <<< FRAC) / a[k][k]);
               lw[i][k] = l;
               for (int j = k; j < n; j++)
                  a[i][j] = fitw(a[i][j] - ((l * a[k][j]) >>> FRAC));
               eT += (W + FRAC + 1) + (n - k) + 1;
            end
         end
      end
      eErr[d] = bad;
      eOvf[d] = mo;
      if (!bad) begin
         for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
               eL[d][r][c] = (r == c) ? (64'sd1 <<< FRAC) : (r > c) ? lw[r][c] : 0;
               eU[d][r][c] = (c >= r) ? a[r][c] : 0;
            end
         end
      end
   endtask

   task automatic reset_exp();
      for (int d = 0; d < 2; d++)
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
               eL[d][r][c] = (r == c) ? (64'sd1 <<< FRAC) : 0;
               eU[d][r][c] = 0;
            end
   endtask

   function automatic longint del(input int d, input bit is_u, input int r, input int c);
      logic [W-1:0] v;
      if (d == 0) v = is_u ? U2[(r*2+c)*W +: W] : L2[(r*2+c)*W +: W];
      else        v = is_u ? U3[(r*3+c)*W +: W] : L3[(r*3+c)*W +: W];
      return longint'(v);
   endfunction

   function automatic logic gbit(input int d, input int which);
      case (which)
         0:       return (d == 0) ? busy2 : busy3;
         1:       return (d == 0) ? done2 : done3;
         2:       return (d == 0) ? err2 : err3;
         default: return (d == 0) ? ovf2 : ovf3;
      endcase
   endfunction

   task automatic check_lu(input int d, input string tag);
      int n;
      n = (d == 0) ? 2 : 3;
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++) begin
            chk($sformatf("%s n%0d L%0d%0d", tag, n, r, c), del(d, 1'b0, r, c), eL[d][r][c] & M);
            chk($sformatf("%s n%0d U%0d%0d", tag, n, r, c), del(d, 1'b1, r, c), eU[d][r][c] & M);
         end
   endtask

   task automatic set_start(input int d, input logic v);
      if (d == 0) start2 = v;
      else        start3 = v;
   endtask

   task automatic load(input int d, input bit scramble);
      logic [W-1:0] t;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            t = scramble ? W'($urandom) : ma[r][c][W-1:0];
            if (d == 1)              A3[(r*3+c)*W +: W] = t;
            else if (r < 2 && c < 2) A2[(r*2+c)*W +: W] = t;
         end
   endtask

   // one run: per-cycle busy/done timeline, results on done, hold afterwards
   task automatic run(input int d, input int extra);
      model(d, (d == 0) ? 2 : 3);
      load(d, 1'b0);
      @(negedge clk); set_start(d, 1'b1);
      @(negedge clk); set_start(d, 1'b0);
      for (int cyc = 1; cyc <= eT; cyc++) begin
         if (cyc > 1) begin
            @(negedge clk);
            set_start(d, 1'b0);
         end
         chk($sformatf("busy c%0d", cyc), gbit(d, 0), (cyc < eT) ? 1 : 0);
         chk($sformatf("done c%0d", cyc), gbit(d, 1), (cyc == eT) ? 1 : 0);
         if (cyc == eT) begin
            chk("err", gbit(d, 2), eErr[d]);
            chk("ovf", gbit(d, 3), eOvf[d]);
            check_lu(d, "done");
         end
         if (cyc == extra) begin
            load(d, 1'b1);
            set_start(d, 1'b1);
         end
      end
      @(negedge clk);
      set_start(d, 1'b0);
      chk("done drop", gbit(d, 1), 0);
      chk("busy idle", gbit(d, 0), 0);
      chk("err hold", gbit(d, 2), eErr[d]);
      check_lu(d, "hold");
   endtask

   task automatic set2(input longint a00, a01, a10, a11);
      ma = '{default: 0};
      ma[0][0] = a00; ma[0][1] = a01; ma[1][0] = a10; ma[1][1] = a11;
   endtask

   initial begin
      int d;
      longint v;
      start2 = 1'b0; start3 = 1'b0; A2 = '0; A3 = '0;
      reset_exp();
      #12;
      for (int k = 0; k < 2; k++) begin
         chk("rst busy", gbit(k, 0), 0);
         chk("rst done", gbit(k, 1), 0);
         chk("rst err", gbit(k, 2), 0);
         chk("rst ovf", gbit(k, 3), 0);
         check_lu(k, "rst");
      end
      @(negedge clk); rst_n = 1'b1;

      set2('h0100, 'h0200, 'h0500, 'h0400);
      run(0, 0);
      chk("t2 T", eT, 29);
      chk("t2 L10", del(0, 0, 1, 0), 'h0500);
      chk("t2 L00", del(0, 0, 0, 0), 'h0100);
      chk("t2 U01", del(0, 1, 0, 1), 'h0200);
      chk("t2 U11", del(0, 1, 1, 1), 'hFA00);

      set2('h0400, 'h0300, 'h0600, 'h0300);
      run(0, 0);
      chk("t3 L10", del(0, 0, 1, 0), 'h0180);
      chk("t3 U11", del(0, 1, 1, 1), 'hFE80);
      chk("t3 U00", del(0, 1, 0, 0), 'h0400);

      set2(0, 'h0100, 'h0100, 0);
      run(0, 1);
      chk("t5 T", eT, 2);
      chk("t5 err", err2, 1);
      chk("t5 keep L10", del(0, 0, 1, 0), 'h0180);
      chk("t5 keep U11", del(0, 1, 1, 1), 'hFE80);

      ma = '{'{'h200, 'h100, 'h100, 0}, '{'h400, 'h300, 'h300, 0},
             '{'h800, 'h700, 'h900, 0}, '{0, 0, 0, 0}};
      load(1, 1'b0);
      @(negedge clk); start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      reset_exp();
      chk("t1 busy", busy3, 0);
      chk("t1 done", done3, 0);
      check_lu(1, "t1 rst");
      check_lu(0, "t1 rst");
      @(negedge clk); rst_n = 1'b1;

      run(1, 5);
      chk("t4 T", eT, 87);
      chk("t4 L10", del(1, 0, 1, 0), 'h0200);
      chk("t4 L20", del(1, 0, 2, 0), 'h0400);
      chk("t4 L21", del(1, 0, 2, 1), 'h0300);
      chk("t4 U11", del(1, 1, 1, 1), 'h0100);
      chk("t4 U12", del(1, 1, 1, 2), 'h0100);
      chk("t4 U22", del(1, 1, 2, 2), 'h0200);

      set2('h0001, 'h0100, 'h7F00, 0);
      run(0, 0);
`ifdef LUD_SAT_EN
      chk("t6 L10", del(0, 0, 1, 0), 'h7FFF);
      chk("t6 ovf", ovf2, 1);
`else
      chk("t6 L10", del(0, 0, 1, 0), 'h0000);
      chk("t6 ovf", ovf2, 0);
`endif

      repeat (30) begin
         d = $urandom_range(0, 1);
         ma = '{default: 0};
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
               if ($urandom_range(0, 3) == 0) begin
                  v = longint'($urandom_range(0, 65535));
                  if (v > 32767) v -= 65536;
               end else begin
                  v = longint'($urandom_range(0, 2047)) - 1024;
               end
               ma[r][c] = v;
            end
         if ($urandom_range(0, 9) == 0) ma[0][0] = 0;
         run(d, $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
